palindrome_engine: RTL

- Parametrised successor to the fixed 32x32 palindrome circuit/control pair: one block holding the register file, front/back pointers, comparator and control FSM.
- Checks whether words rf[base..ending] form a palindrome.
- Two modes:
  - Word mode: rf[front] == rf[back].
  - Digit-mirror mode: rf[front] equals rf[back] with its DIGIT-bit groups reversed in order.
- Sits beside the lab datapath. It is loaded through its own write port and started with a level go / done handshake.

---
 rtl/palindrome_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/palindrome_engine.sv
// Palindrome checker over a private register file: walks front/back
// pointers inward comparing words, either directly or with one side
// digit-reversed, and reports pass/fail plus the first failing front index.
module palindrome_engine #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int DIGIT = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             go,
    input  logic             mode,
    input  logic [AW-1:0]    base,
    input  logic [AW-1:0]    ending,
    output logic             busy,
    output logic             done,
    output logic             palindrome,
    output logic             error,
    output logic [AW-1:0]    mismatch_addr
);

    localparam int NDIG = WIDTH / DIGIT;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    typedef struct packed {
        logic          pal;
        logic          err;
        logic [AW-1:0] mis;
    } result_t;

    state_t                       state, state_nx;
    logic [AW-1:0]                front, back, front_nx, back_nx;
    logic                         mode_q, mode_nx;
    result_t                      res, res_nx;
    logic [DEPTH-1:0][WIDTH-1:0]  rf;
    logic [WIDTH-1:0]             rd_front, rd_back, back_rev;
    logic                         word_eq, mirr_eq;

    assign rd_front = rf[front];
    assign rd_back  = rf[back];

    // Digit-group reversal of the back word; bit order inside a group is kept.
    for (genvar g = 0; g < NDIG; g++) begin : g_rev
        assign back_rev[g*DIGIT +: DIGIT] = rd_back[(NDIG-1-g)*DIGIT +: DIGIT];
    end

    assign word_eq = (rd_front == rd_back);
    assign mirr_eq = (rd_front == back_rev);

    assign busy          = (state == CHECK);
    assign done          = (state == DONE);
    assign palindrome    = res.pal;
    assign error         = res.err;
    assign mismatch_addr = res.mis;

    // Register file: writes only land while no check is walking the pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf <= '0;
        end else if (we && state != CHECK) begin
            rf[waddr] <= wdata;
        end
    end

    // State, pointers, latched mode and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            front  <= '0;
            back   <= '0;
            mode_q <= 1'b0;
            res    <= '0;
        end else begin
            state  <= state_nx;
            front  <= front_nx;
            back   <= back_nx;
            mode_q <= mode_nx;
            res    <= res_nx;
        end
    end

    // Next-state logic: one pair compared per cycle while in CHECK.
    always_comb begin
        state_nx = state;
        front_nx = front;
        back_nx  = back;
        mode_nx  = mode_q;
        res_nx   = res;
        unique case (state)
            IDLE: begin
                if (go) begin
                    res_nx   = '0;
                    front_nx = base;
                    back_nx  = ending;
                    mode_nx  = mode;
                    if (base > ending) begin
                        res_nx.err = 1'b1;
                        state_nx   = DONE;
                    end else begin
                        state_nx = CHECK;
                    end
                end
            end
            CHECK: begin
                if (!mode_q) begin
                    if (front >= back) begin
                        res_nx.pal = 1'b1;
                        state_nx   = DONE;
                    end else if (!word_eq) begin
                        res_nx.mis = front;
                        state_nx   = DONE;
                    end else begin
                        front_nx = front + AW'(1);
                        back_nx  = back - AW'(1);
                    end
                end else begin
                    // Mirror mode also checks the middle word against itself.
                    if (front > back) begin
                        res_nx.pal = 1'b1;
                        state_nx   = DONE;
                    end else if (!mirr_eq) begin
                        res_nx.mis = front;
                        state_nx   = DONE;
                    end else if (front == back) begin
                        res_nx.pal = 1'b1;
                        state_nx   = DONE;
                    end else begin
                        front_nx = front + AW'(1);
                        back_nx  = back - AW'(1);
                    end
                end
            end
            DONE: begin
                if (!go) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
